// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package mem_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} resp_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int LAT_W = 4;
endpackage

// File: rtl/data_mem_array.sv
// Word-organised backing RAM: synchronous byte-enabled write, combinational read.
module data_mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);
   logic [31:0] mem_q [DEPTH_WORDS];

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: stalls MEM for LATENCY cycles after accepting a
// load/store, then presents an extended load result and a one-cycle response pulse.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH_WORDS   = 1024,
   parameter int LATENCY       = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     memreqm,
   input  logic                     memwritem,
   input  logic [2:0]               funct3m,
   input  logic [ADDRESS_WIDTH-1:0] addrm,
   input  logic [DATA_WIDTH-1:0]    writedatam,
   output logic                     stallm,
   output logic [DATA_WIDTH-1:0]    readdatam,
   output logic                     respvalidm,
   output logic                     misalignm
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   resp_state_t           state_q, state_d;
   logic [LAT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q;
   logic [1:0]            lo_q;
   logic [2:0]            f3_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_d;

   logic                  accept, commit, is_b, is_h, mis_c;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, load_ext;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;

   assign accept = (state_q == IDLE) && memreqm;
   // Last WAIT cycle: the single edge where the store lands and the load is captured.
   assign commit = (state_q == WAIT) && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lo_q    <= '0;
         f3_q    <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (accept) begin
            idx_q   <= addrm[2 +: IDX_W];
            lo_q    <= addrm[1:0];
            f3_q    <= funct3m;
            write_q <= memwritem;
            wdata_q <= writedatam;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: if (memreqm) begin
            state_d = WAIT;
            cnt_d   = LAT_W'(LATENCY - 1);
         end
         WAIT: if (cnt_q == '0) state_d = DONE;
               else             cnt_d   = cnt_q - 1'b1;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stallm     = accept || (state_q == WAIT);
      respvalidm = (state_q == DONE);
      misalignm  = (state_q == DONE) && mis_c;
   end

   // Size decode; anything that is not a byte or half access behaves as a word.
   assign is_b  = (f3_q == F3_B) || (f3_q == F3_BU);
   assign is_h  = (f3_q == F3_H) || (f3_q == F3_HU);
   assign mis_c = (is_h && lo_q[0]) || ((f3_q == F3_W) && (lo_q != 2'b00));

   always_comb begin
      be        = 4'b1111;
      ram_wdata = wdata_q;
      if (is_b) begin
         be        = 4'b0001 << lo_q;
         ram_wdata = {4{wdata_q[7:0]}};
      end else if (is_h) begin
         be        = lo_q[1] ? 4'b1100 : 4'b0011;
         ram_wdata = {2{wdata_q[15:0]}};
      end
   end

   assign byte_v = ram_rdata[8*lo_q +: 8];
   assign half_v = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

   always_comb begin
      unique case (f3_q)
         F3_B:    load_ext = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_ext = {24'd0, byte_v};
         F3_H:    load_ext = {{16{half_v[15]}}, half_v};
         F3_HU:   load_ext = {16'd0, half_v};
         default: load_ext = ram_rdata;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (commit && !write_q) rdata_d = load_ext;
   end

   assign readdatam = rdata_q;

   data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
      .clk_i   (clk),
      .we_i    (commit && write_q),
      .be_i    (be),
      .idx_i   (idx_q),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus randomized traffic against a word-array model.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        memwritem = 1'b0;
   logic [2:0]  funct3m = 3'b0;
   logic [31:0] addrm = '0, writedatam = '0;
   logic [2:0]  memreq = '0;
   logic [2:0]  stall, rvalid, misv;
   logic [31:0] rdata [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(2)) u0 (
      .clk(clk), .rst_n(rst_n), .memreqm(memreq[0]), .memwritem(memwritem), .funct3m(funct3m),
      .addrm(addrm), .writedatam(writedatam), .stallm(stall[0]), .readdatam(rdata[0]),
      .respvalidm(rvalid[0]), .misalignm(misv[0]));
   data_mem_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .memreqm(memreq[1]), .memwritem(memwritem), .funct3m(funct3m),
      .addrm(addrm), .writedatam(writedatam), .stallm(stall[1]), .readdatam(rdata[1]),
      .respvalidm(rvalid[1]), .misalignm(misv[1]));
   data_mem_responder #(.LATENCY(15)) u2 (
      .clk(clk), .rst_n(rst_n), .memreqm(memreq[2]), .memwritem(memwritem), .funct3m(funct3m),
      .addrm(addrm), .writedatam(writedatam), .stallm(stall[2]), .readdatam(rdata[2]),
      .respvalidm(rvalid[2]), .misalignm(misv[2]));

   // Starts just after a rising edge; returns just after the edge that leaves DONE,
   // so the next call presents its request in the cycle right after DONE.
   task automatic do_access(input int idx, input bit w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output bit mis, output int stalls,
                            output bit first_stall, output bit done_stall, output bit timeout);
      memwritem = w; funct3m = f3; addrm = a; writedatam = wd;
      memreq[idx] = 1'b1;
      stalls = 0; timeout = 1'b1; rd = '0; mis = 1'b0; done_stall = 1'b0;
      @(negedge clk);
      first_stall = stall[idx];
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rvalid[idx]) begin
            rd = rdata[idx]; mis = misv[idx]; done_stall = stall[idx]; timeout = 1'b0;
            break;
         end
         if (stall[idx]) stalls++;
      end
      @(posedge clk);
      #1 memreq[idx] = 1'b0;
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] a);
      logic [31:0] v;
      case (f3)
         3'b000: begin v = (word >> (8 * (a % 4))) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
         3'b100: v = (word >> (8 * (a % 4))) & 32'hFF;
         3'b001: begin v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
         3'b101: v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] m;
      int sh;
      case (f3)
         3'b000: begin sh = 8 * (a % 4);        m = 32'hFF << sh;   return (word & ~m) | ((wd & 32'hFF) << sh); end
         3'b001: begin sh = 16 * ((a / 2) % 2); m = 32'hFFFF << sh; return (word & ~m) | ((wd & 32'hFFFF) << sh); end
         default: return wd;
      endcase
   endfunction

   function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
      return ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 == 1)) || (f3 == 3'b010 && (a % 4 != 0));
   endfunction

   task automatic test_reset();
      #12;
      checks++; if (stall[0] !== 1'b0)    begin errors++; $display("FAIL reset_stall got=%b want=0", stall[0]); end
      checks++; if (rdata[0] !== 32'h0)   begin errors++; $display("FAIL reset_rdata got=%h want=0", rdata[0]); end
      checks++; if (rvalid[0] !== 1'b0)   begin errors++; $display("FAIL reset_rvalid got=%b want=0", rvalid[0]); end
      checks++; if (misv[0] !== 1'b0)     begin errors++; $display("FAIL reset_mis got=%b want=0", misv[0]); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      logic [31:0] rd; bit mis, fs, ds, to; int st;
      do_access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, mis, st, fs, ds, to);
      checks++; if (to)         begin errors++; $display("FAIL sw_timeout got=timeout want=respvalid"); end
      checks++; if (fs !== 1'b1) begin errors++; $display("FAIL sw_accept_stall got=%b want=1", fs); end
      checks++; if (st != 2)    begin errors++; $display("FAIL sw_stall_len got=%0d want=2", st); end
      checks++; if (ds !== 1'b0) begin errors++; $display("FAIL sw_done_stall got=%b want=0", ds); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata_hold got=%h want=0", rd); end
      do_access(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_raw got=%h want=deadbeef", rd); end
      checks++; if (mis !== 1'b0) begin errors++; $display("FAIL lw_mis got=%b want=0", mis); end
   endtask

   task automatic test_subword();
      logic [31:0] rd; bit mis, fs, ds, to; int st;
      do_access(0, 0, 3'b000, 32'h13, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got=%h want=ffffffde", rd); end
      do_access(0, 0, 3'b100, 32'h13, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu got=%h want=000000de", rd); end
      do_access(0, 0, 3'b001, 32'h12, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh got=%h want=ffffdead", rd); end
      do_access(0, 0, 3'b101, 32'h12, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL lhu got=%h want=0000dead", rd); end
      do_access(0, 1, 3'b000, 32'h11, 32'h55, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL sb_rdata_hold got=%h want=0000dead", rd); end
      do_access(0, 0, 3'b010, 32'h10, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge got=%h want=dead55ef", rd); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; bit mis, fs, ds, to; int st;
      do_access(0, 1, 3'b010, 32'h04, 32'hA5A59234, rd, mis, st, fs, ds, to);
      do_access(0, 0, 3'b010, 32'h06, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hA5A59234) begin errors++; $display("FAIL lw_mis_data got=%h want=a5a59234", rd); end
      checks++; if (mis !== 1'b1)        begin errors++; $display("FAIL lw_mis_flag got=%b want=1", mis); end
      do_access(0, 0, 3'b001, 32'h05, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hFFFF9234) begin errors++; $display("FAIL lh_mis_data got=%h want=ffff9234", rd); end
      checks++; if (mis !== 1'b1)        begin errors++; $display("FAIL lh_mis_flag got=%b want=1", mis); end
      do_access(0, 0, 3'b011, 32'h06, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hA5A59234) begin errors++; $display("FAIL undef_f3_data got=%h want=a5a59234", rd); end
      checks++; if (mis !== 1'b0)        begin errors++; $display("FAIL undef_f3_flag got=%b want=0", mis); end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd; bit mis, fs, ds, to; int st;
      do_access(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, rd, mis, st, fs, ds, to);
      memwritem = 1'b1; funct3m = 3'b010; addrm = 32'h20; writedatam = 32'h12345678;
      memreq[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (stall[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b want=1", stall[0]); end
      rst_n = 1'b0; memreq[0] = 1'b0;
      #1;
      checks++; if (stall[0] !== 1'b0)  begin errors++; $display("FAIL rst_mid_stall got=%b want=0", stall[0]); end
      checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h want=0", rdata[0]); end
      @(posedge clk); #1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      do_access(0, 0, 3'b010, 32'h20, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_store_dropped got=%h want=cafef00d", rd); end
   endtask

   task automatic test_latency();
      logic [31:0] rd; bit mis, fs, ds, to; int st;
      do_access(1, 1, 3'b010, 32'h1000, 32'h0BADF00D, rd, mis, st, fs, ds, to);
      checks++; if (st != 1 || to) begin errors++; $display("FAIL lat1_stall_len got=%0d want=1", st); end
      do_access(1, 0, 3'b010, 32'h0, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL lat1_alias got=%h want=0badf00d", rd); end
      do_access(2, 1, 3'b010, 32'h40, 32'h13572468, rd, mis, st, fs, ds, to);
      checks++; if (st != 15 || to) begin errors++; $display("FAIL lat15_stall_len got=%0d want=15", st); end
      do_access(2, 0, 3'b010, 32'h40, 32'h0, rd, mis, st, fs, ds, to);
      checks++; if (rd !== 32'h13572468) begin errors++; $display("FAIL lat15_data got=%h want=13572468", rd); end
      checks++; if (ds !== 1'b0) begin errors++; $display("FAIL lat15_done_stall got=%b want=0", ds); end
   endtask

   // Back-to-back random traffic on a 16-word window; stores expect readdatam unchanged.
   task automatic test_back_to_back_random();
      logic [31:0] mdl [16];
      logic [31:0] rd, last_rd, a, wd, exp_rd;
      logic [2:0]  f3;
      bit mis, fs, ds, to, w;
      int st, wi;
      for (int i = 0; i < 16; i++) begin
         mdl[i] = $urandom;
         do_access(0, 1, 3'b010, 32'h100 + 4 * i, mdl[i], rd, mis, st, fs, ds, to);
      end
      do_access(0, 0, 3'b010, 32'h100, 32'h0, rd, mis, st, fs, ds, to);
      last_rd = mdl[0];
      checks++; if (rd !== last_rd) begin errors++; $display("FAIL rnd_init got=%h want=%h", rd, last_rd); end
      for (int n = 0; n < 80; n++) begin
         w  = $urandom_range(0, 1);
         f3 = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         a  = 32'h100 + $urandom_range(0, 63);
         wd = $urandom;
         wi = int'((a - 32'h100) / 4);
         do_access(0, w, f3, a, wd, rd, mis, st, fs, ds, to);
         if (w) begin
            mdl[wi] = model_store(mdl[wi], f3, a, wd);
            exp_rd  = last_rd;
         end else begin
            exp_rd  = model_load(mdl[wi], f3, a);
            last_rd = exp_rd;
         end
         checks++; if (to || rd !== exp_rd) begin errors++; $display("FAIL rnd_data n=%0d w=%0b f3=%0d a=%h got=%h want=%h", n, w, f3, a, rd, exp_rd); end
         checks++; if (mis !== model_mis(f3, a)) begin errors++; $display("FAIL rnd_mis n=%0d got=%b want=%b", n, mis, model_mis(f3, a)); end
         checks++; if (st != 2) begin errors++; $display("FAIL rnd_stall_len n=%0d got=%0d want=2", n, st); end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_subword();
      test_misalign();
      test_reset_mid_access();
      test_latency();
      test_back_to_back_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
